// File: rtl/nios2_oci_dct_trace_fifo.sv
// Capture FIFO for the OCI data-capture-trace stream: count-tagged words, valid/ready drain,
// backpressure or drop-and-count on full, and an end-of-test drain sequence.
module nios2_oci_dct_trace_fifo #(
    parameter int DATA_W       = 30,
    parameter int CNT_W        = 4,
    parameter int DEPTH        = 16,
    parameter int DROP_ON_FULL = 0,
    parameter int OVF_W        = 16,
    parameter int TOT_W        = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dct_valid,
    output logic                     dct_ready,
    input  logic [DATA_W-1:0]        dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    input  logic                     test_ending,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CNT_W-1:0]         out_count,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [OVF_W-1:0]         overflow_count,
    output logic [TOT_W-1:0]         word_total,
    output logic [1:0]               state,
    output logic                     test_has_ended
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int ENT_W  = DATA_W + CNT_W;
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + OVF_W'(1);
    endfunction

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic [TOT_W-1:0]  tot_q, tot_d;
    state_e            state_q;
    logic              ended_q;
    logic              full, ready_int, valid_int, offer, pop, accept, drop;
    logic [ENT_W-1:0]  head;

    always_comb begin
        full      = (fill_q == FULL_LVL);
        ready_int = (state_q == ST_RUN) && ((DROP_ON_FULL != 0) || !full);
        valid_int = (fill_q != '0) && (state_q != ST_DONE);
        pop       = valid_int && out_ready;
        // Zero-count words are swallowed here so they never reach the queue or counters.
        offer     = dct_valid && ready_int && (dct_count != '0);
        accept    = offer && (!full || pop);
        drop      = (DROP_ON_FULL != 0) && offer && full && !pop;

        wr_d  = accept ? wr_q + PTR_W'(1) : wr_q;
        rd_d  = pop ? rd_q + PTR_W'(1) : rd_q;
        ovf_d = drop ? sat_inc(ovf_q) : ovf_q;
        tot_d = accept ? tot_q + TOT_W'(1) : tot_q;
        unique case ({accept, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            mem_q[wr_q] <= {dct_count, dct_buffer};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
            ovf_q  <= '0;
            tot_q  <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
            tot_q  <= tot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            ended_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (test_ending) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fill_q == '0) begin
                        state_q <= ST_DONE;
                        ended_q <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_DONE;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Every output reads zero for as long as reset is held, not just after the edge.
    assign head           = mem_q[rd_q];
    assign dct_ready      = !reset && ready_int;
    assign out_valid      = !reset && valid_int;
    assign out_data       = reset ? '0 : head[DATA_W-1:0];
    assign out_count      = reset ? '0 : head[ENT_W-1:DATA_W];
    assign fill_level     = reset ? '0 : fill_q;
    assign overflow_count = reset ? '0 : ovf_q;
    assign word_total     = reset ? '0 : tot_q;
    assign state          = reset ? 2'd0 : state_q;
    assign test_has_ended = !reset && ended_q;
endmodule

// File: tb/tb_nios2_oci_dct_trace_fifo.sv
// Directed bench: one backpressure instance and one drop-on-full instance share stimulus.
module tb_nios2_oci_dct_trace_fifo;
    localparam int DATA_W = 30, CNT_W = 4, DEPTH = 16, OVF_W = 16, TOT_W = 32;

    logic clk = 1'b0, reset = 1'b1;
    logic dct_valid = 1'b0, test_ending = 1'b0, out_ready = 1'b0;
    logic [DATA_W-1:0] dct_buffer = '0;
    logic [CNT_W-1:0]  dct_count = '0;

    logic dct_ready0, dct_ready1, out_valid0, out_valid1, ended0, ended1;
    logic [DATA_W-1:0] out_data0, out_data1;
    logic [CNT_W-1:0]  out_count0, out_count1;
    logic [4:0]        fill0, fill1;
    logic [OVF_W-1:0]  ovf0, ovf1;
    logic [TOT_W-1:0]  tot0, tot1;
    logic [1:0]        st0, st1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nios2_oci_dct_trace_fifo #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .DROP_ON_FULL(0),
                               .OVF_W(OVF_W), .TOT_W(TOT_W)) u0 (
        .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_ready(dct_ready0),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_count(out_count0), .fill_level(fill0), .overflow_count(ovf0),
        .word_total(tot0), .state(st0), .test_has_ended(ended0));

    nios2_oci_dct_trace_fifo #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .DROP_ON_FULL(1),
                               .OVF_W(OVF_W), .TOT_W(TOT_W)) u1 (
        .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_ready(dct_ready1),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_count(out_count1), .fill_level(fill1), .overflow_count(ovf1),
        .word_total(tot1), .state(st1), .test_has_ended(ended1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; dct_valid = 1'b0; test_ending = 1'b0; out_ready = 1'b0;
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        step(); step();
        chk("rst_ready0", dct_ready0, 0);
        chk("rst_ready1", dct_ready1, 0);
        chk("rst_valid0", out_valid0, 0);
        chk("rst_fill0", fill0, 0);
        chk("rst_state0", st0, 0);
        chk("rst_ended0", ended0, 0);
        reset = 1'b0;
        #1;
        chk("run_ready0", dct_ready0, 1);
        chk("run_ready1", dct_ready1, 1);

        // Basic flow: five count=3 words, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            dct_valid = 1'b1; dct_buffer = DATA_W'(i); dct_count = 4'd3;
            step();
            if (i == 1) begin
                chk("lat_valid0", out_valid0, 1);
                chk("lat_data0", out_data0, 1);
            end
        end
        dct_valid = 1'b0;
        chk("basic_fill0", fill0, 5);
        chk("basic_total0", tot0, 5);
        chk("basic_fill1", fill1, 5);
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("basic_data0", out_data0, i);
            chk("basic_cnt0", out_count0, 3);
            chk("basic_data1", out_data1, i);
            step();
        end
        out_ready = 1'b0;
        chk("basic_empty_fill0", fill0, 0);
        chk("basic_empty_valid0", out_valid0, 0);

        // Zero-count word between two count=2 words.
        do_reset();
        dct_valid = 1'b1;
        dct_buffer = 30'hA; dct_count = 4'd2; step();
        dct_buffer = 30'hB; dct_count = 4'd0; step();
        dct_buffer = 30'hC; dct_count = 4'd2; step();
        dct_valid = 1'b0;
        chk("zc_fill0", fill0, 2);
        chk("zc_total0", tot0, 2);
        chk("zc_ovf1", ovf1, 0);
        out_ready = 1'b1;
        chk("zc_head0", out_data0, 30'hA);
        step();
        chk("zc_second0", out_data0, 30'hC);
        step();
        out_ready = 1'b0;
        chk("zc_drained0", fill0, 0);

        // Twenty words into a full queue: backpressure vs drop.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            dct_valid = 1'b1; dct_buffer = DATA_W'(32'h100 + i); dct_count = 4'd1;
            chk("bp_ready0", dct_ready0, (i < 16) ? 1 : 0);
            chk("drop_ready1", dct_ready1, 1);
            step();
        end
        dct_valid = 1'b0;
        chk("full_fill0", fill0, 16);
        chk("full_fill1", fill1, 16);
        chk("full_total0", tot0, 16);
        chk("full_total1", tot1, 16);
        chk("full_ovf0", ovf0, 0);
        chk("full_ovf1", ovf1, 4);

        // Pop and offer together at full: drop mode accepts, backpressure mode refuses.
        out_ready = 1'b1; dct_valid = 1'b1; dct_buffer = 30'h200; dct_count = 4'd1;
        chk("pp_ready0", dct_ready0, 0);
        chk("pp_head0", out_data0, 30'h100);
        chk("pp_head1", out_data1, 30'h100);
        step();
        chk("pp_fill0", fill0, 15);
        chk("pp_fill1", fill1, 16);
        chk("pp_total1", tot1, 17);
        chk("pp_ovf1", ovf1, 4);
        out_ready = 1'b0;
        step();
        dct_valid = 1'b0;
        chk("refill_fill0", fill0, 16);
        chk("refill_total0", tot0, 17);
        chk("refill_ovf1", ovf1, 5);
        chk("refill_total1", tot1, 17);
        out_ready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            chk("full_data0", out_data0, (j < 16) ? (32'h100 + j) : 32'h200);
            chk("full_data1", out_data1, (j < 16) ? (32'h100 + j) : 32'h200);
            step();
        end
        out_ready = 1'b0;
        chk("full_drained0", fill0, 0);
        chk("full_drained1", fill1, 0);

        // End of test with three words queued.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            dct_valid = 1'b1; dct_buffer = DATA_W'(32'h30 + i); dct_count = 4'd1;
            step();
        end
        dct_valid = 1'b0;
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        chk("eot_state0", st0, 1);
        chk("eot_state1", st1, 1);
        chk("eot_ready0", dct_ready0, 0);
        chk("eot_ready1", dct_ready1, 0);
        dct_valid = 1'b1; dct_buffer = 30'h99; dct_count = 4'd1;
        step(); step();
        dct_valid = 1'b0;
        chk("eot_ignored_fill0", fill0, 3);
        chk("eot_ignored_total1", tot1, 3);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            chk("eot_data0", out_data0, 32'h30 + i);
            step();
        end
        chk("eot_drained_fill0", fill0, 0);
        chk("eot_still_drain0", st0, 1);
        chk("eot_not_ended0", ended0, 0);
        step();
        chk("eot_done0", st0, 2);
        chk("eot_ended0", ended0, 1);
        chk("eot_ended1", ended1, 1);
        chk("eot_done_valid0", out_valid0, 0);
        out_ready = 1'b0;
        test_ending = 1'b1; step(); test_ending = 1'b0;
        step(); step();
        chk("eot_sticky0", ended0, 1);
        chk("eot_sticky_state0", st0, 2);
        chk("eot_frozen_total0", tot0, 3);

        // End of test with the queue empty: flag two edges after test_ending.
        do_reset();
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        chk("emp_state_e1", st0, 1);
        chk("emp_ended_e1", ended0, 0);
        step();
        chk("emp_state_e2", st0, 2);
        chk("emp_ended_e2", ended0, 1);

        // Reset while draining four words.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            dct_valid = 1'b1; dct_buffer = DATA_W'(32'h40 + i); dct_count = 4'd2;
            step();
        end
        dct_valid = 1'b0;
        test_ending = 1'b1; step(); test_ending = 1'b0;
        chk("rd_state0", st0, 1);
        chk("rd_fill0", fill0, 4);
        reset = 1'b1;
        #1;
        chk("rd_hold_ready0", dct_ready0, 0);
        chk("rd_hold_fill0", fill0, 0);
        chk("rd_hold_total0", tot0, 0);
        chk("rd_hold_valid0", out_valid0, 0);
        step();
        reset = 1'b0;
        #1;
        chk("rd_after_fill0", fill0, 0);
        chk("rd_after_state0", st0, 0);
        chk("rd_after_ended0", ended0, 0);
        chk("rd_after_total0", tot0, 0);
        chk("rd_after_ready0", dct_ready0, 1);
        chk("rd_after_ready1", dct_ready1, 1);
        chk("rd_after_valid0", out_valid0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
